// File: rtl/icache_axi_rd_bridge_pkg.sv
// Shared AXI constants and bridge state encoding for the I-cache refill bridge.
package icache_axi_rd_bridge_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_AR   = 2'd1;
  localparam logic [1:0] STATE_R    = 2'd2;
  localparam logic [1:0] STATE_DONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = STATE_IDLE,
    ST_AR   = STATE_AR,
    ST_R    = STATE_R,
    ST_DONE = STATE_DONE
  } bridge_state_e;

endpackage

// File: rtl/icache_axi_rd_bridge.sv
// I-cache line refill to single AXI4 INCR read burst; returns the assembled line as a one-cycle pulse.
// Optional response checking on axi_err is enabled by defining ICACHE_AXI_CHECK_EN.
module icache_axi_rd_bridge
  import icache_axi_rd_bridge_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned ID_WIDTH       = 4,
  parameter int unsigned AXI_ID         = 0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 icache_rd_req,
  input  logic [31:0]                          icache_rd_addr,
  output logic                                 icache_rd_rdy,
  output logic                                 icache_ret_valid,
  output logic [WORDS_PER_LINE*DATA_WIDTH-1:0] icache_ret_data,
  output logic [ID_WIDTH-1:0]                  arid,
  output logic [31:0]                          araddr,
  output logic [7:0]                           arlen,
  output logic [2:0]                           arsize,
  output logic [1:0]                           arburst,
  output logic [1:0]                           arlock,
  output logic [3:0]                           arcache,
  output logic [2:0]                           arprot,
  output logic                                 arvalid,
  input  logic                                 arready,
  input  logic [ID_WIDTH-1:0]                  rid,
  input  logic [DATA_WIDTH-1:0]                rdata,
  input  logic [1:0]                           rresp,
  input  logic                                 rlast,
  input  logic                                 rvalid,
  output logic                                 rready,
  output logic                                 axi_err
);

  localparam int unsigned LINE_W = WORDS_PER_LINE * DATA_WIDTH;
  localparam int unsigned BEAT_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam int unsigned OFF_W  = $clog2(WORDS_PER_LINE * 4);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);

  bridge_state_e     state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              beat_hs_c;

  // Line offset bits never reach the bus.
  logic unused_addr_bits;
  assign unused_addr_bits = ^icache_rd_addr[OFF_W-1:0];

  assign beat_hs_c = (state_q == ST_R) & rvalid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      beat_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    beat_d  = beat_q;
    line_d  = line_q;
    case (state_q)
      ST_IDLE: begin
        if (icache_rd_req) begin
          addr_d  = {icache_rd_addr[31:OFF_W], OFF_W'(0)};
          beat_d  = '0;
          state_d = ST_AR;
        end
      end
      ST_AR: begin
        if (arready) begin
          state_d = ST_R;
        end
      end
      ST_R: begin
        // The beat counter alone decides when the line is complete.
        if (beat_hs_c) begin
          line_d[beat_q*DATA_WIDTH +: DATA_WIDTH] = rdata;
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == LAST_BEAT) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign arvalid          = (state_q == ST_AR);
  assign rready           = (state_q == ST_R);
  assign icache_rd_rdy    = arvalid & arready;
  assign icache_ret_valid = (state_q == ST_DONE);
  assign icache_ret_data  = line_q;

  assign arid    = ID_WIDTH'(AXI_ID);
  assign araddr  = addr_q;
  assign arlen   = 8'(WORDS_PER_LINE - 1);
  assign arsize  = SIZE_4B;
  assign arburst = BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

`ifdef ICACHE_AXI_CHECK_EN
  logic err_q, err_d;
  logic last_beat_c;

  assign last_beat_c = (beat_q == LAST_BEAT);

  // Sticky until reset; the line itself is delivered regardless.
  always_comb begin
    err_d = err_q;
    if (beat_hs_c && ((rresp != RESP_OKAY) || (rid != ID_WIDTH'(AXI_ID)) ||
                      (rlast != last_beat_c))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign axi_err = err_q;
`else
  logic unused_r_bits;
  assign unused_r_bits = ^{rid, rresp, rlast};
  assign axi_err       = 1'b0;
`endif

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Directed self-checking bench for icache_axi_rd_bridge (default parameters).
module tb_icache_axi_rd_bridge;

  localparam int unsigned DW  = 32;
  localparam int unsigned WPL = 4;
  localparam int unsigned IDW = 4;

`ifdef ICACHE_AXI_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              icache_rd_req;
  logic [31:0]       icache_rd_addr;
  logic              icache_rd_rdy;
  logic              icache_ret_valid;
  logic [WPL*DW-1:0] icache_ret_data;
  logic [IDW-1:0]    arid;
  logic [31:0]       araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [1:0]        arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [IDW-1:0]    rid;
  logic [DW-1:0]     rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;
  logic              axi_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  icache_axi_rd_bridge dut (
    .clk              (clk),
    .reset            (reset),
    .icache_rd_req    (icache_rd_req),
    .icache_rd_addr   (icache_rd_addr),
    .icache_rd_rdy    (icache_rd_rdy),
    .icache_ret_valid (icache_ret_valid),
    .icache_ret_data  (icache_ret_data),
    .arid             (arid),
    .araddr           (araddr),
    .arlen            (arlen),
    .arsize           (arsize),
    .arburst          (arburst),
    .arlock           (arlock),
    .arcache          (arcache),
    .arprot           (arprot),
    .arvalid          (arvalid),
    .arready          (arready),
    .rid              (rid),
    .rdata            (rdata),
    .rresp            (rresp),
    .rlast            (rlast),
    .rvalid           (rvalid),
    .rready           (rready),
    .axi_err          (axi_err)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Request in IDLE, zero-wait AR handshake; returns in the first R cycle.
  task automatic issue(input logic [31:0] addr, input logic [31:0] exp_addr);
    icache_rd_req  = 1'b1;
    icache_rd_addr = addr;
    arready        = 1'b1;
    #1;
    chk("rdy_low_in_idle", icache_rd_rdy, 0);
    nxt();
    chk("arvalid", arvalid, 1);
    chk("araddr", araddr, exp_addr);
    chk("rdy_handshake", icache_rd_rdy, 1);
    icache_rd_req = 1'b0;
    nxt();
  endtask

  // gap idle cycles, then one accepted beat; returns the cycle after acceptance.
  task automatic beat(input logic [31:0] d, input logic last, input int gap, input logic [1:0] resp);
    rvalid = 1'b0;
    repeat (gap) begin
      #1;
      chk("no_ret_in_gap", icache_ret_valid, 0);
      nxt();
    end
    rvalid = 1'b1;
    rdata  = d;
    rlast  = last;
    rresp  = resp;
    #1;
    chk("rready_on_beat", rready, 1);
    nxt();
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    icache_rd_req  = 1'b0;
    icache_rd_addr = '0;
    arready        = 1'b0;
    rid            = '0;
    rdata          = '0;
    rresp          = 2'b00;
    rlast          = 1'b0;
    rvalid         = 1'b0;
    nxt();
    nxt();
    reset = 1'b0;
    #1;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_rdy", icache_rd_rdy, 0);
    chk("rst_ret_valid", icache_ret_valid, 0);
    chk("rst_ret_data", icache_ret_data, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_axi_err", axi_err, 0);

    // Zero-wait burst: ret_valid six cycles after req.
    icache_rd_req  = 1'b1;
    icache_rd_addr = 32'h1FC0_0014;
    arready        = 1'b1;
    #1;
    chk("t1_rdy_idle", icache_rd_rdy, 0);
    nxt();
    chk("t1_arvalid", arvalid, 1);
    chk("t1_araddr", araddr, 32'h1FC0_0010);
    chk("t1_arlen", arlen, 3);
    chk("t1_arsize", arsize, 2);
    chk("t1_arburst", arburst, 1);
    chk("t1_arid", arid, 0);
    chk("t1_arlock", arlock, 0);
    chk("t1_arcache", arcache, 0);
    chk("t1_arprot", arprot, 0);
    chk("t1_rdy", icache_rd_rdy, 1);
    icache_rd_req = 1'b0;
    nxt();
    chk("t1_rready", rready, 1);
    chk("t1_arvalid_off", arvalid, 0);
    beat(32'hA0, 1'b0, 0, 2'b00);
    beat(32'hA1, 1'b0, 0, 2'b00);
    beat(32'hA2, 1'b0, 0, 2'b00);
    chk("t1_no_early_ret", icache_ret_valid, 0);
    beat(32'hA3, 1'b1, 0, 2'b00);
    chk("t1_ret_valid", icache_ret_valid, 1);
    chk("t1_ret_data", icache_ret_data, 128'h000000A3_000000A2_000000A1_000000A0);
    chk("t1_rready_done", rready, 0);
    nxt();
    chk("t1_ret_pulse_end", icache_ret_valid, 0);
    chk("t1_ret_data_hold", icache_ret_data, 128'h000000A3_000000A2_000000A1_000000A0);

    // AR stalled five cycles, then beats with gaps 0,3,1,2.
    icache_rd_req  = 1'b1;
    icache_rd_addr = 32'h00AB_CDEC;
    arready        = 1'b0;
    nxt();
    for (int i = 0; i < 5; i++) begin
      chk("t2_arvalid_stall", arvalid, 1);
      chk("t2_araddr_stall", araddr, 32'h00AB_CDE0);
      chk("t2_rdy_stall", icache_rd_rdy, 0);
      nxt();
    end
    arready = 1'b1;
    #1;
    chk("t2_rdy_handshake", icache_rd_rdy, 1);
    chk("t2_arvalid_hs", arvalid, 1);
    icache_rd_req = 1'b0;
    nxt();
    beat(32'hB0, 1'b0, 0, 2'b00);
    beat(32'hB1, 1'b0, 3, 2'b00);
    beat(32'hB2, 1'b0, 1, 2'b00);
    beat(32'hB3, 1'b1, 2, 2'b00);
    chk("t2_ret_valid", icache_ret_valid, 1);
    chk("t2_ret_data", icache_ret_data, 128'h000000B3_000000B2_000000B1_000000B0);
    nxt();
    chk("t2_ret_single", icache_ret_valid, 0);

    // Back-to-back: request in the IDLE cycle right after DONE.
    issue(32'h2000_004C, 32'h2000_0040);
    chk("t3_data_held", icache_ret_data, 128'h000000B3_000000B2_000000B1_000000B0);
    beat(32'hC0, 1'b0, 0, 2'b00);
    beat(32'hC1, 1'b0, 0, 2'b00);
    beat(32'hC2, 1'b0, 0, 2'b00);
    beat(32'hC3, 1'b1, 0, 2'b00);
    chk("t3_ret_valid", icache_ret_valid, 1);
    chk("t3_ret_data", icache_ret_data, 128'h000000C3_000000C2_000000C1_000000C0);
    chk("t3_axi_err", axi_err, 0);
    nxt();

    // Reset after two beats aborts to IDLE.
    issue(32'h0000_5670, 32'h0000_5670);
    beat(32'hD0, 1'b0, 0, 2'b00);
    beat(32'hD1, 1'b0, 0, 2'b00);
    rvalid = 1'b1;
    rdata  = 32'hD2;
    reset  = 1'b1;
    nxt();
    reset  = 1'b0;
    rvalid = 1'b0;
    #1;
    chk("t4_arvalid", arvalid, 0);
    chk("t4_rready", rready, 0);
    chk("t4_ret_valid", icache_ret_valid, 0);
    chk("t4_ret_data", icache_ret_data, 0);
    issue(32'h0000_1238, 32'h0000_1230);
    beat(32'hE0, 1'b0, 0, 2'b00);
    beat(32'hE1, 1'b0, 0, 2'b00);
    beat(32'hE2, 1'b0, 0, 2'b00);
    beat(32'hE3, 1'b1, 0, 2'b00);
    chk("t4_ret_valid_after", icache_ret_valid, 1);
    chk("t4_ret_data_after", icache_ret_data, 128'h000000E3_000000E2_000000E1_000000E0);
    nxt();

    // SLVERR on beat 1.
    issue(32'h0000_8000, 32'h0000_8000);
    beat(32'hF0, 1'b0, 0, 2'b00);
    chk("t5_err_before", axi_err, 0);
    beat(32'hF1, 1'b0, 0, 2'b10);
    chk("t5_err_set", axi_err, ERR_EXP);
    beat(32'hF2, 1'b0, 0, 2'b00);
    beat(32'hF3, 1'b1, 0, 2'b00);
    chk("t5_ret_valid", icache_ret_valid, 1);
    chk("t5_ret_data", icache_ret_data, 128'h000000F3_000000F2_000000F1_000000F0);
    chk("t5_err_held", axi_err, ERR_EXP);
    nxt();
    nxt();
    chk("t5_err_sticky", axi_err, ERR_EXP);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/icache_axi_rd_bridge.md
Name: icache_axi_rd_bridge

Overview:
- Sits directly downstream of the instruction cache refill port.
- Converts one cache-line refill request into a single AXI4 INCR read burst.
- Assembles the returned beats into one line and hands it back to the cache as a single-cycle pulse.
- One outstanding refill at a time; read-only (no AW/W/B channels).

Parameters:
- DATA_WIDTH, 32, AXI data bus width and cache word width.
- WORDS_PER_LINE, 4, beats per burst; ARLEN = WORDS_PER_LINE-1.
- ID_WIDTH, 4, AXI ID width.
- AXI_ID, 0, constant ARID value driven on every burst.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- icache_rd_req  in  1  refill request; held high until icache_rd_rdy is seen.
- icache_rd_addr  in  32  line address; low log2(WORDS_PER_LINE*4) bits ignored.
- icache_rd_rdy  out  1  request accepted (AR handshake cycle).
- icache_ret_valid  out  1  one-cycle pulse: full line valid.
- icache_ret_data  out  WORDS_PER_LINE*DATA_WIDTH  line; word k at bits [32k+31:32k].
- arid  out  ID_WIDTH  = AXI_ID.
- araddr  out  32  latched line address, offset bits forced to 0.
- arlen  out  8  = WORDS_PER_LINE-1.
- arsize  out  3  = 3'b010.
- arburst  out  2  = 2'b01 (INCR).
- arlock  out  2  = 0.
- arcache  out  4  = 0.
- arprot  out  3  = 0.
- arvalid  out  1  AR valid.
- arready  in  1  AR ready.
- rid  in  ID_WIDTH  R id.
- rdata  in  DATA_WIDTH  R data.
- rresp  in  2  R response.
- rlast  in  1  R last.
- rvalid  in  1  R valid.
- rready  out  1  R ready.
- axi_err  out  1  sticky error flag (see Optional Feature).

Behaviour:
- Reset values: state IDLE; arvalid 0; rready 0; icache_rd_rdy 0; icache_ret_valid 0; line buffer, beat counter, latched address 0; axi_err 0.
- Reset mid-burst aborts immediately to IDLE. Outstanding AXI beats are not drained, because the whole system resets together.
- IDLE:
  - If icache_rd_req=1, latch icache_rd_addr with offset bits cleared, clear the beat counter, go to AR.
  - icache_rd_rdy=0 in IDLE.
- AR:
  - arvalid=1, araddr stable.
  - icache_rd_rdy = arvalid & arready (combinational, exactly the handshake cycle).
  - On handshake, go to R. Otherwise stay; arvalid is never dropped before arready.
- R:
  - rready=1.
  - Each rvalid&rready cycle writes rdata into buffer word[beat] and increments beat (2 bits for the default, wraps).
  - The beat with beat==WORDS_PER_LINE-1 goes to DONE. Control uses the counter only; rlast and rid do not steer the FSM.
- DONE:
  - icache_ret_valid=1 for exactly one cycle, icache_ret_data = buffer.
  - Go to IDLE. icache_ret_data holds its value until the next burst writes it.
- A request in the IDLE cycle right after DONE is accepted normally, giving back-to-back refills.
- icache_rd_req while not in IDLE is ignored; the cache holds it only until rd_rdy.
- Minimum latency, req high at cycle T:
  - AR at T+1 (rd_rdy at T+1 if arready=1).
  - Beats from T+2.
  - ret_valid one cycle after the last beat is accepted, i.e. T+6 with zero-wait slave.
- Beats with rvalid=0 stall the counter; there is no timeout.

Optional Feature:
- Macro ICACHE_AXI_CHECK_EN.
- Defined: axi_err is set and held until reset on any accepted beat with:
  - rresp != 0, or
  - rid != AXI_ID, or
  - rlast=1 on a beat other than the final one, or
  - rlast=0 on the final beat.
  
  Line data is still delivered unchanged.
- Undefined: axi_err tied 0; no checking logic is instantiated.

Decomposition:
- The shared package holds:
  - AXI constants: BURST_INCR=2'b01, SIZE_4B=3'b010, RESP_OKAY=2'b00.
  - Bridge state encoding: IDLE, AR, R, DONE as 2-bit localparams.
- No sub-module; beat counter and line buffer stay inline.

Test Plan:
- Zero-wait slave, req with addr 0x1FC0_0014:
  - araddr=0x1FC0_0010, arlen=3, arsize=2, arburst=1.
  - Beats 0xA0..0xA3 -> ret_valid pulse one cycle after the 4th beat, ret_data=0x000000A3_000000A2_000000A1_000000A0.
- arready held low 5 cycles -> arvalid and araddr stable all 5 cycles; rd_rdy only in the handshake cycle; req held by cache until then.
- rvalid gaps of 0,3,1,2 cycles between beats -> words land in slots 0..3 in order; exactly one ret_valid pulse.
- Back-to-back: second req asserted in the IDLE cycle after DONE -> second AR issued next cycle; first ret_data unchanged until the second burst's beats arrive.
- Reset asserted after 2 beats -> next cycle state IDLE, arvalid/rready/ret_valid 0; a fresh req afterwards completes a correct burst.
- With ICACHE_AXI_CHECK_EN: rresp=2'b10 on beat 1 -> axi_err=1 from the next cycle and stays 1; line still returned. Without the macro, axi_err stays 0.
